// File: rtl/trng_sampler.sv
// trng_sampler: consumer end of the ring-oscillator entropy chain.
// Enables a bank of free-running ROs, synchronises and XOR-combines their
// outputs, samples at a programmable rate, applies von Neumann debiasing and
// packs the bits into WORD_W-bit words presented over a valid/ready handshake.
// Optional feature macro: TRNG_HEALTH_EN (repetition-count health test on raw).
module trng_sampler #(
  parameter int unsigned NUM_RO     = 4,
  parameter int unsigned WORD_W     = 32,
  parameter int unsigned DIV_W      = 8,
  parameter int unsigned WARMUP_CYC = 16,
  parameter int unsigned RCT_LIMIT  = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              en,
  input  logic [DIV_W-1:0]  div,
  input  logic [NUM_RO-1:0] ro_in,
  output logic [NUM_RO-1:0] ro_en,
  output logic [WORD_W-1:0] data,
  output logic              valid,
  input  logic              ready,
  output logic              health_fail
);

  localparam int unsigned WU_W = $clog2(WARMUP_CYC + 1);
  localparam int unsigned BC_W = $clog2(WORD_W + 1);

  typedef enum logic [1:0] {
    IDLE,
    WARMUP,
    COLLECT,
    FULL
  } state_t;

  state_t state, state_nxt;

  logic [NUM_RO-1:0] sync1, sync2;
  logic              raw;
  logic [DIV_W-1:0]  div_cnt;
  logic [WU_W-1:0]   warm_cnt;
  logic [BC_W-1:0]   bit_cnt;
  logic              pair_have, pair_a;
  logic [WORD_W-1:0] shreg, shreg_nxt;
  logic              tick, emit, word_done, warm_done, accept;
  logic              block;

  assign raw = ^sync2;

  // State register
  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next-state logic and the per-cycle strobes the datapath acts on
  always_comb begin
    tick      = (state == COLLECT) && (div_cnt == div);
    emit      = tick && pair_have && (pair_a != raw);
    word_done = emit && (bit_cnt == BC_W'(WORD_W - 1)) && !block;
    warm_done = (state == WARMUP) && (warm_cnt == WU_W'(WARMUP_CYC - 1));
    accept    = (state == FULL) && valid && ready;
    shreg_nxt = (shreg << 1) | WORD_W'(pair_a);
    state_nxt = state;
    if (!en) begin
      state_nxt = IDLE;
    end else begin
      case (state)
        IDLE:    state_nxt = WARMUP;
        WARMUP:  if (warm_done) state_nxt = COLLECT;
        COLLECT: if (word_done) state_nxt = FULL;
        FULL:    if (accept) state_nxt = COLLECT;
        default: state_nxt = IDLE;
      endcase
    end
  end

  // Synchronisers, counters, debias pair, shift register and output word
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync1     <= '0;
      sync2     <= '0;
      ro_en     <= '0;
      data      <= '0;
      valid     <= 1'b0;
      div_cnt   <= '0;
      warm_cnt  <= '0;
      bit_cnt   <= '0;
      pair_have <= 1'b0;
      pair_a    <= 1'b0;
      shreg     <= '0;
    end else begin
      sync1 <= ro_in;
      sync2 <= sync1;
      if (!en) begin
        ro_en     <= '0;
        valid     <= 1'b0;
        div_cnt   <= '0;
        warm_cnt  <= '0;
        bit_cnt   <= '0;
        pair_have <= 1'b0;
      end else begin
        case (state)
          IDLE: begin
            ro_en    <= '1;
            warm_cnt <= '0;
          end
          WARMUP: begin
            warm_cnt <= warm_cnt + 1'b1;
            if (warm_done) begin
              div_cnt   <= '0;
              pair_have <= 1'b0;
              bit_cnt   <= '0;
            end
          end
          COLLECT: begin
            div_cnt <= tick ? '0 : div_cnt + 1'b1;
            if (tick) begin
              if (!pair_have) begin
                pair_a    <= raw;
                pair_have <= 1'b1;
              end else begin
                pair_have <= 1'b0;
                if (emit && !block) begin
                  shreg   <= shreg_nxt;
                  bit_cnt <= bit_cnt + 1'b1;
                  if (word_done) begin
                    data  <= shreg_nxt;
                    valid <= 1'b1;
                  end
                end
              end
            end
          end
          FULL: begin
            if (accept) begin
              valid     <= 1'b0;
              bit_cnt   <= '0;
              pair_have <= 1'b0;
              div_cnt   <= '0;
            end
          end
          default: ;
        endcase
      end
    end
  end

`ifdef TRNG_HEALTH_EN
  localparam int unsigned RC_W = $clog2(RCT_LIMIT + 1);

  logic [RC_W-1:0] rct_cnt, rct_nxt;
  logic            rct_last;
  logic            hf;

  // Run length of identical raw samples; a count of 0 means no prior sample
  always_comb begin
    rct_nxt = rct_cnt;
    if (tick) begin
      if ((rct_cnt != '0) && (raw == rct_last))
        rct_nxt = (rct_cnt == RC_W'(RCT_LIMIT)) ? rct_cnt : rct_cnt + 1'b1;
      else
        rct_nxt = RC_W'(1);
    end
    block = hf || (rct_nxt >= RC_W'(RCT_LIMIT));
  end

  // Sticky failure flag, cleared only by reset or a return to IDLE
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rct_cnt  <= '0;
      rct_last <= 1'b0;
      hf       <= 1'b0;
    end else if (!en || (state == IDLE)) begin
      rct_cnt  <= '0;
      hf       <= 1'b0;
    end else if (tick) begin
      rct_cnt  <= rct_nxt;
      rct_last <= raw;
      if (rct_nxt >= RC_W'(RCT_LIMIT)) hf <= 1'b1;
    end
  end

  assign health_fail = hf;
`else
  assign block       = 1'b0;
  assign health_fail = 1'b0;
`endif

endmodule

// File: tb/tb_trng_sampler.sv
// Scoreboard bench for trng_sampler: per-run input sequences are generated up
// front, a tick-time/von-Neumann reference model turns them into expected
// words, and a negedge monitor compares each word the DUT presents.
module tb_trng_sampler;
  localparam int unsigned NUM_RO     = 4;
  localparam int unsigned WORD_W     = 32;
  localparam int unsigned DIV_W      = 8;
  localparam int unsigned WARMUP_CYC = 16;
  localparam int unsigned RCT_LIMIT  = 32;
  localparam int MAXE = 40000;

  localparam int M_RAND = 0, M_TOGGLE = 1, M_CONST = 2, M_PAT55 = 3;
  localparam int R_RAND = 0, R_ALWAYS = 1, R_PULSE = 2, R_NEVER = 3;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              en = 1'b0;
  logic [DIV_W-1:0]  div = '0;
  logic [NUM_RO-1:0] ro_in = '0;
  logic [NUM_RO-1:0] ro_en;
  logic [WORD_W-1:0] data;
  logic              valid;
  logic              ready = 1'b0;
  logic              health_fail;

  trng_sampler #(
    .NUM_RO(NUM_RO), .WORD_W(WORD_W), .DIV_W(DIV_W),
    .WARMUP_CYC(WARMUP_CYC), .RCT_LIMIT(RCT_LIMIT)
  ) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .div(div), .ro_in(ro_in),
    .ro_en(ro_en), .data(data), .valid(valid), .ready(ready),
    .health_fail(health_fail)
  );

  always #5 clk = ~clk;

  int edge_no = 0;
  always @(posedge clk) edge_no <= edge_no + 1;

  bit [NUM_RO-1:0] ro_seq [MAXE];
  bit              rdy_seq [MAXE];

  typedef struct {
    logic [WORD_W-1:0] word;
    int                tw;
  } exp_t;

  exp_t q[$];
  int n_vec = 0;
  int n_bad = 0;
  logic [WORD_W-1:0] exp_data = '0;
  bit                cur_valid = 1'b0;
  logic [WORD_W-1:0] cur_data = '0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    n_vec++;
    if (act !== expv) begin
      n_bad++;
      $display("FAIL %s: actual %h, required %h (edge %0d)", name, act, expv, edge_no);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  // Reference: enable at edge e0, collection starts WARMUP_CYC edges later,
  // ticks every dv+1 edges, each tick sees raw = XOR of ro_in two edges back.
  // After a word, collection restarts at the first later edge with ready=1.
  task automatic model(input int e0, input int dv, input int eend);
    int t, h, bits;
    bit have_a, a, r;
    logic [WORD_W-1:0] w;
    exp_t e;
    t = e0 + WARMUP_CYC;
    bits = 0;
    have_a = 0;
    a = 0;
    w = '0;
    while (1) begin
      t = t + dv + 1;
      if (t >= eend) break;
      r = ^ro_seq[t-2];
      if (!have_a) begin
        a = r;
        have_a = 1;
      end else begin
        have_a = 0;
        if (a != r) begin
          w = {w[WORD_W-2:0], a};
          bits++;
          if (bits == WORD_W) begin
            e.word = w;
            e.tw = t;
            q.push_back(e);
            exp_data = w;
            h = t + 1;
            while (h < eend && !rdy_seq[h]) h++;
            if (h >= eend) break;
            t = h;
            bits = 0;
          end
        end
      end
    end
  endtask

  task automatic run(input int mode, input int dv, input int rmode, input int len,
                     input bit by_reset, input bit ovr, input logic [WORD_W-1:0] ovr_word);
    int e0, s, eend, sz0, j;
    exp_t tmp;
    e0 = edge_no + 1;
    s = e0 + WARMUP_CYC;
    eend = e0 + len;
    for (int e = e0; e <= eend + 2; e++) begin
      case (mode)
        M_RAND:   ro_seq[e] = NUM_RO'($urandom_range(0, 15));
        M_TOGGLE: ro_seq[e] = NUM_RO'(((e - s + 1000 * (dv + 1)) / (dv + 1)) % 2);
        M_CONST:  ro_seq[e] = NUM_RO'(1);
        default: begin
          j = (e - s + 1 + 1000) % 4;
          ro_seq[e] = NUM_RO'((j == 1 || j == 2) ? 1 : 0);
        end
      endcase
      case (rmode)
        R_RAND:   rdy_seq[e] = ($urandom_range(0, 3) != 0);
        R_ALWAYS: rdy_seq[e] = 1'b1;
        R_PULSE:  rdy_seq[e] = (e == s + 400);
        default:  rdy_seq[e] = 1'b0;
      endcase
      if (e >= eend) rdy_seq[e] = 1'b0;
    end
    sz0 = q.size();
    model(e0, dv, eend);
    if (ovr && q.size() > sz0) begin
      tmp = q[sz0];
      tmp.word = ovr_word;
      q[sz0] = tmp;
      if (q.size() == sz0 + 1) exp_data = ovr_word;
    end
    div = DIV_W'(dv);
    for (int e = e0; e <= eend; e++) begin
      en = (e < eend);
      ro_in = ro_seq[e];
      ready = rdy_seq[e];
      if (by_reset && e == eend) begin
        chk("full_before_reset", 32'(valid), 32'd1);
        rst_n = 1'b0;
      end
`ifdef TRNG_HEALTH_EN
      if (mode == M_CONST && e == eend) chk("health_fail_const", 32'(health_fail), 32'd1);
`endif
      step();
      if (e == e0) chk("ro_en_on", 32'(ro_en), 32'((1 << NUM_RO) - 1));
    end
    rst_n = 1'b1;
    en = 1'b0;
    ready = 1'b0;
    if (by_reset) exp_data = '0;
    chk("valid_off", 32'(valid), 32'd0);
    chk("ro_en_off", 32'(ro_en), 32'd0);
    chk("data_hold", data, exp_data);
    chk("words_missing", 32'(q.size()), 32'd0);
`ifndef TRNG_HEALTH_EN
    chk("health_fail_tied", 32'(health_fail), 32'd0);
`endif
    q.delete();
    step();
  endtask

  // Monitor: compares each presented word and its arrival edge; checks data stays put
  always @(negedge clk) begin
    exp_t e;
    if (rst_n) begin
      if (valid && !cur_valid) begin
        chk("word_expected", 32'(q.size() != 0), 32'd1);
        if (q.size() != 0) begin
          e = q.pop_front();
          chk("word_time", 32'(edge_no), 32'(e.tw));
          chk("word_data", data, e.word);
        end
        cur_valid = 1'b1;
        cur_data = data;
      end else if (valid && cur_valid) begin
        chk("data_stable", data, cur_data);
      end
      if (!valid || ready) cur_valid = 1'b0;
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    repeat (3) step();
    chk("rst_valid", 32'(valid), 32'd0);
    chk("rst_data", data, 32'd0);
    chk("rst_ro_en", 32'(ro_en), 32'd0);
    chk("rst_health", 32'(health_fail), 32'd0);
    rst_n = 1'b1;
    step();

    run(M_TOGGLE, 0, R_ALWAYS, 300, 1'b0, 1'b1, 32'hFFFF_FFFF);
    run(M_PAT55,  0, R_ALWAYS, 200, 1'b0, 1'b1, 32'h5555_5555);
    run(M_CONST,  0, R_RAND,   300, 1'b0, 1'b0, '0);
    run(M_TOGGLE, 3, R_PULSE,  800, 1'b0, 1'b0, '0);
    run(M_TOGGLE, 0, R_NEVER,  200, 1'b1, 1'b1, 32'hFFFF_FFFF);

    // Abort during warm-up, then check a fresh enable restarts warm-up from 0
    for (int i = 0; i < 5; i++) begin
      en = 1'b1;
      step();
    end
    en = 1'b0;
    step();
    chk("abort_ro_en", 32'(ro_en), 32'd0);
    chk("abort_valid", 32'(valid), 32'd0);

    for (int i = 0; i < 8; i++)
      run(M_RAND, (i < 3) ? i : int'($urandom_range(0, 5)), R_RAND, 2500, 1'b0, 1'b0, '0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/trng_sampler.md
Name: trng_sampler

Overview:
- Consumer end of the ring-oscillator entropy chain: enables a bank of free-running ROs, synchronises their asynchronous outputs, XOR-combines and samples them at a programmable rate.
- Applies von Neumann debiasing and packs the resulting bits into words.
- Presents words to the TinyQV peripheral register layer over a valid/ready handshake.

Parameters:
- NUM_RO, 4, number of RO inputs harvested (≥1).
- WORD_W, 32, output word width in bits.
- DIV_W, 8, width of sample-divider input.
- WARMUP_CYC, 16, clk cycles to wait after RO enable before sampling (≥1).
- RCT_LIMIT, 32, repetition-count threshold for the health test (used only with TRNG_HEALTH_EN).

Ports:
- clk, input, 1, system clock.
- rst_n, input, 1, synchronous active-low reset.
- en, input, 1, harvest enable.
- div, input, DIV_W, sample period minus 1 (0 = sample every cycle).
- ro_in, input, NUM_RO, asynchronous RO outputs.
- ro_en, output, NUM_RO, RO enable (all bits identical).
- data, output, WORD_W, random word.
- valid, output, 1, data holds an unread word.
- ready, input, 1, consumer accepts data.
- health_fail, output, 1, sticky health-test failure.

Behaviour:
- Reset (rst_n=0 at posedge clk): state IDLE. ro_en=0, data=0, valid=0, health_fail=0. Synchronisers, counters, debias pair and shift register cleared.
- Synchroniser: each ro_in bit passes through 2 flops. raw = XOR of the synchronised bits. An ro_in change reaches raw 2 cycles later.
- Sample tick: div counter runs only in COLLECT.
  - Tick when counter == div, then counter → 0.
  - A div change takes effect at the next compare.
- State machine:
  - IDLE: ro_en=0. On en=1 → WARMUP, ro_en=all 1s, warmup counter=0.
  - WARMUP: counter increments each cycle. At count WARMUP_CYC-1 → COLLECT, with div counter, pair flag and bit count cleared.
  - COLLECT: on each tick, raw is sampled.
    - First sample of a pair is stored.
    - On the second sample, pair (a,b): 01 → emit 0, 10 → emit 1, 00/11 → discard. The pair flag clears in all cases.
    - Emitted bit enters shift register LSB; existing bits shift left.
    - When the emitted bit is the WORD_W-th, the full word (including that bit) is copied to data on the same edge, valid=1, → FULL.
  - FULL: sampling paused, ROs stay enabled. On valid&ready: valid=0 next cycle, bit count=0, → COLLECT (pair flag and div counter cleared).
  - Any state with en=0: → IDLE next cycle, ro_en=0, valid=0, counters/pair cleared. data holds its last value.
- data is stable while valid=1. ready with valid=0 is ignored.
- With div=0 and no discards, the first word is valid at cycle WARMUP_CYC + 2·WORD_W after en, plus 1 registered cycle.

Optional Feature:
- Macro: TRNG_HEALTH_EN.
- Defined: repetition-count test on raw at every tick in COLLECT.
  - A counter of consecutive identical samples reaches RCT_LIMIT → health_fail=1 (sticky).
  - health_fail clears only on reset or a return to IDLE.
  - While health_fail=1, valid is forced 0, no new word is latched, and the state stays COLLECT.
- Not defined: no test logic; health_fail tied 0.

Test Plan:
- Reset mid-FULL: with valid=1, rst_n=0 for 1 cycle → next cycle valid=0, data=0, ro_en=0, state IDLE.
- NUM_RO=4, div=0, en=1, ro_in=4'b0001 constant → raw always 1, all pairs 11 discarded, valid stays 0. With TRNG_HEALTH_EN, health_fail=1 after 32 ticks.
- ro_in[0] toggled every clk, others 0, div=0 → pairs 10 every 2 ticks. data=32'hFFFFFFFF and valid=1 after 64 ticks; ro_en=4'hF from cycle after en.
- Same stimulus with div=3, ready held 0 → valid asserts after 256 ticks-worth of cycles and holds. data is unchanged for 100 further cycles. Pulse ready → valid=0 next cycle, collection resumes.
- en deasserted during WARMUP (cycle 5) → IDLE next cycle, ro_en=0, valid never asserts. Re-assert en → WARMUP restarts from 0.
- Pattern producing pairs 01,10,01,10,… → data=32'h55555555.
